acc_unit: RTL and testbench

Parametrised accumulator for the processor datapath: holds the A operand, loads it from the data bus or the external input, and performs add, subtract, shifts and an iterative unsigned multiply against the data bus. Status flags feed the control unit's conditional branches. It generalises the 8-bit A-register datapath with a width parameter, carry/overflow flags, shift modes, and a multi-cycle multiply with a start/busy/done handshake.

---
 rtl/acc_pkg.sv | 23 ++
 rtl/acc_unit_if.sv | 29 ++
 rtl/acc_unit_addsub.sv | 25 ++
 rtl/acc_unit.sv | 125 ++++++++++++
 tb/tb_acc_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accumulator unit.
// Holds the operation codes, FSM states and the default datapath width.
package acc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDD = 3'd1,
        OP_LDI = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/acc_unit_if.sv
// Bus bundle between the control unit and the accumulator.
// master: drives data/Input/op/start; slave: drives busy/done/Output/flags.
interface acc_unit_if
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] Input;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Output;
    logic             Aeq0;
    logic             Apos;
    logic             carry;
    logic             ovf;

    modport master (
        output data, Input, op, start,
        input  busy, done, Output, Aeq0, Apos, carry, ovf
    );

    modport slave (
        input  data, Input, op, start,
        output busy, done, Output, Aeq0, Apos, carry, ovf
    );
endinterface

// File: rtl/acc_unit_addsub.sv
// Combinational add/subtract shared by ADD, SUB and the multiply step.
// Ports: a, b operands; sub selects a-b; sum, carry (borrow on sub), ovf.
module addsub_w
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic             c_out;

    // Subtraction as a + ~b + 1; the carry-out is then the inverse of borrow.
    assign b_eff = sub ? ~b : b;
    assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff}
                        + {{WIDTH{1'b0}}, sub};
    assign carry = sub ? ~c_out : c_out;
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1])
                && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/acc_unit.sv
// Accumulator (A register) with load, add, sub, shifts and shift-add multiply.
// Ports: clk, reset (sync, active-high), bus (acc_unit_if slave).
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic       clk,
    input logic       reset,
    acc_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] MUL  = ST_MUL;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0] prod;
    logic               carry_q;
    logic               ovf_q;
    logic               done_q;

    op_e op;
    assign op = op_e'(bus.op);

    logic [WIDTH-1:0]   as_a;
    logic [WIDTH-1:0]   as_b;
    logic               as_sub;
    logic [WIDTH-1:0]   as_sum;
    logic               as_c;
    logic               as_v;
    logic [2*WIDTH-1:0] prod_nxt;

    // While multiplying, the adder accumulates the multiplicand (A, which is
    // held unchanged) into the upper product half when the current
    // multiplier bit, prod[0], is set.
    always_comb begin
        as_a   = acc;
        as_b   = bus.data;
        as_sub = (op == OP_SUB);
        if (state == MUL) begin
            as_a   = prod[2*WIDTH-1:WIDTH];
            as_b   = prod[0] ? acc : '0;
            as_sub = 1'b0;
        end
    end

    addsub_w #(.WIDTH(WIDTH)) u_addsub (
        .a     (as_a),
        .b     (as_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_c),
        .ovf   (as_v)
    );

    // Shift right after the add: the multiplier bits leave at the bottom
    // while product bits enter at the top.
    assign prod_nxt = {as_c, as_sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    done_q <= (op != OP_MUL);
                    unique case (op)
                        OP_NOP: ;
                        OP_LDD: acc <= bus.data;
                        OP_LDI: acc <= bus.Input;
                        OP_ADD, OP_SUB: begin
                            acc     <= as_sum;
                            carry_q <= as_c;
                            ovf_q   <= as_v;
                        end
                        OP_SHL: begin
                            acc     <= {acc[WIDTH-2:0], 1'b0};
                            carry_q <= acc[WIDTH-1];
                            ovf_q   <= acc[WIDTH-1] ^ acc[WIDTH-2];
                        end
                        OP_SHR: begin
                            acc     <= {acc[WIDTH-1], acc[WIDTH-1:1]};
                            carry_q <= acc[0];
                            ovf_q   <= 1'b0;
                        end
                        OP_MUL: begin
                            state <= MUL;
                            cnt   <= '0;
                            prod  <= {{WIDTH{1'b0}}, bus.data};
                        end
                    endcase
                end
            end else begin
                prod <= prod_nxt;
                cnt  <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    acc     <= prod_nxt[WIDTH-1:0];
                    carry_q <= |prod_nxt[2*WIDTH-1:WIDTH];
                    ovf_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.Output = acc;
    assign bus.Aeq0   = (acc == '0);
    assign bus.Apos   = ~acc[WIDTH-1];
    assign bus.busy   = (state == MUL);
    assign bus.done   = done_q;
    assign bus.carry  = carry_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit (WIDTH=8): vector table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_acc_unit;
    import acc_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    acc_unit_if #(.WIDTH(W)) bus ();

    acc_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int m_a = 0;
    int m_c = 0;
    int m_v = 0;

    typedef struct {
        int op;
        int d;
        int i;
        int eo;
        int ec;
        int ev;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void model(input int op, input int d, input int i);
        int s;
        case (op)
            1: m_a = d;
            2: m_a = i;
            3: begin
                s   = sx(m_a) + sx(d);
                m_v = (s > 127 || s < -128) ? 1 : 0;
                m_c = (m_a + d > 255) ? 1 : 0;
                m_a = (m_a + d) % 256;
            end
            4: begin
                s   = sx(m_a) - sx(d);
                m_v = (s > 127 || s < -128) ? 1 : 0;
                m_c = (m_a < d) ? 1 : 0;
                m_a = (m_a - d + 256) % 256;
            end
            5: begin
                m_c = m_a / 128;
                m_v = (m_a / 128) ^ ((m_a / 64) % 2);
                m_a = (m_a * 2) % 256;
            end
            6: begin
                m_c = m_a % 2;
                m_v = 0;
                m_a = m_a / 2 + ((m_a >= 128) ? 128 : 0);
            end
            7: begin
                s   = m_a * d;
                m_c = (s / 256 != 0) ? 1 : 0;
                m_v = 0;
                m_a = s % 256;
            end
            default: ;
        endcase
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".Output"}, bus.Output, m_a);
        chk({tag, ".carry"}, bus.carry, m_c);
        chk({tag, ".ovf"}, bus.ovf, m_v);
        chk({tag, ".Aeq0"}, bus.Aeq0, (m_a == 0) ? 1 : 0);
        chk({tag, ".Apos"}, bus.Apos, (m_a < 128) ? 1 : 0);
    endtask

    // One op: drive at a falling edge, sample at following falling edges.
    task automatic exec(input int op, input int d, input int i,
                        input bit poke, input string tag);
        int old;
        int nb;
        @(negedge clk);
        chk({tag, ".idle_done"}, bus.done, 0);
        bus.op    = op[2:0];
        bus.data  = d[W-1:0];
        bus.Input = i[W-1:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        old = m_a;
        model(op, d, i);
        if (op == 7) begin
            bus.data = W'($urandom);
            nb = 0;
            while (bus.busy === 1'b1 && nb < 20) begin
                chk({tag, ".hold"}, bus.Output, old);
                chk({tag, ".no_done"}, bus.done, 0);
                nb++;
                if (poke) begin
                    bus.start = 1'b1;
                    bus.op    = 3'd3;
                end
                @(negedge clk);
            end
            bus.start = 1'b0;
            chk({tag, ".busy_cycles"}, nb, W);
        end else begin
            chk({tag, ".busy"}, bus.busy, 0);
        end
        chk({tag, ".done"}, bus.done, 1);
        chk_state(tag);
    endtask

    vec_t tv[$];

    initial begin
        bus.op    = '0;
        bus.data  = '0;
        bus.Input = '0;
        bus.start = 1'b0;
        reset     = 1'b1;

        tv.push_back('{1, 8'h7F, 0,     8'h7F, 0, 0});
        tv.push_back('{3, 8'h01, 0,     8'h80, 0, 1});
        tv.push_back('{3, 8'h80, 0,     8'h00, 1, 1});
        tv.push_back('{1, 8'h05, 0,     8'h05, 1, 1});
        tv.push_back('{4, 8'h05, 0,     8'h00, 0, 0});
        tv.push_back('{4, 8'h01, 0,     8'hFF, 1, 0});
        tv.push_back('{2, 0,     8'h81, 8'h81, 1, 0});
        tv.push_back('{5, 0,     0,     8'h02, 1, 1});
        tv.push_back('{2, 0,     8'h81, 8'h81, 1, 1});
        tv.push_back('{6, 0,     0,     8'hC0, 1, 0});
        tv.push_back('{0, 8'h3C, 8'h11, 8'hC0, 1, 0});

        repeat (2) @(negedge clk);
        chk("rst.Output", bus.Output, 0);
        chk("rst.Aeq0", bus.Aeq0, 1);
        chk("rst.Apos", bus.Apos, 1);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.carry", bus.carry, 0);
        chk("rst.ovf", bus.ovf, 0);
        reset = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            exec(tv[k].op, tv[k].d, tv[k].i, 1'b0, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d.tab_out", k), bus.Output, tv[k].eo);
            chk($sformatf("vec%0d.tab_c", k), bus.carry, tv[k].ec);
            chk($sformatf("vec%0d.tab_v", k), bus.ovf, tv[k].ev);
        end

        exec(1, 13, 0, 1'b0, "mul_ld");
        exec(7, 11, 0, 1'b1, "mul13x11");
        chk("mul13x11.val", bus.Output, 8'h8F);
        chk("mul13x11.c", bus.carry, 0);
        exec(1, 8'h20, 0, 1'b0, "mul_ld2");
        exec(7, 8'h10, 0, 1'b0, "mul20x10");
        chk("mul20x10.val", bus.Output, 8'h00);
        chk("mul20x10.c", bus.carry, 1);

        @(negedge clk);
        bus.op    = 3'd1;
        bus.data  = 8'h10;
        bus.start = 1'b1;
        @(negedge clk);
        model(1, 8'h10, 0);
        chk("b2b1.done", bus.done, 1);
        chk("b2b1.Output", bus.Output, m_a);
        bus.op   = 3'd3;
        bus.data = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        model(3, 8'h01, 0);
        chk("b2b2.done", bus.done, 1);
        chk("b2b2.Output", bus.Output, m_a);

        exec(1, 8'h55, 0, 1'b0, "abort_ld");
        @(negedge clk);
        bus.op    = 3'd7;
        bus.data  = 8'h03;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort.busy1", bus.busy, 1);
        repeat (3) @(negedge clk);
        chk("abort.busy4", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_a = 0;
        m_c = 0;
        m_v = 0;
        chk("abort.busy", bus.busy, 0);
        chk("abort.done", bus.done, 0);
        chk_state("abort");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("abort.late_done", {bus.done, bus.busy}, 2'b00);
        end
        exec(1, 8'h33, 0, 1'b0, "after_abort");

        for (int k = 0; k < 150; k++) begin
            exec(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b0,
                 $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
